// File: rtl/decode_ctl.sv
// Front-end sequencer: credit-limited sequential fetch, in-order response queue,
// one instruction per cycle to decode, redirect/flush with in-flight drain.
module decode_ctl #(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            reset,
  output logic            fetch_req_fe,
  output logic [XLEN-1:0] fetch_pc_fe,
  input  logic            fetch_gnt_fe,
  input  logic            fetch_rsp_valid_fe,
  input  logic [31:0]     fetch_rsp_instr_fe,
  input  logic            stall_de0,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic            valid_de0,
  output logic [31:0]     instr_de0,
  output logic [XLEN-1:0] pc_de0,
  output logic            empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0]     LP_DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]   LP_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0]   LP_ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]   LP_PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] LP_FOUR    = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [XLEN-1:0] LP_ALIGN   = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic [CW-1:0]   r_outst, w_outst_nxt;
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [XLEN-1:0] r_fetch_pc, r_rsp_pc;
  logic [31:0]     r_q_instr [DEPTH];
  logic [XLEN-1:0] r_q_pc    [DEPTH];
  logic [CW:0]     w_used;
  logic            w_req, w_issue, w_push, w_pop, w_valid;
  logic [XLEN-1:0] w_flush_pc;

  // Credits are computed from registered occupancy/outstanding only.
  assign w_used     = {1'b0, r_count} + {1'b0, r_outst};
  assign w_req      = (r_state == ST_RUN) && (w_used < LP_DEPTH_W);
  assign w_issue    = w_req && fetch_gnt_fe;
  assign w_valid    = (r_state == ST_RUN) && (r_count != LP_ZERO);
  assign w_push     = fetch_rsp_valid_fe && (r_state == ST_RUN) && !flush;
  assign w_pop      = w_valid && !stall_de0 && !flush;
  assign w_flush_pc = flush_pc & LP_ALIGN;

  // Next state, outstanding and occupancy
  always_comb begin
    w_state_nxt = r_state;
    w_outst_nxt = r_outst;
    w_count_nxt = r_count;
    case ({w_issue, fetch_rsp_valid_fe})
      2'b10:   w_outst_nxt = r_outst + LP_ONE;
      2'b01:   w_outst_nxt = r_outst - LP_ONE;
      default: w_outst_nxt = r_outst;
    endcase
    if (flush) begin
      w_count_nxt = LP_ZERO;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + LP_ONE;
        2'b01:   w_count_nxt = r_count - LP_ONE;
        default: w_count_nxt = r_count;
      endcase
    end
    if (flush) begin
      if (w_outst_nxt != LP_ZERO) begin
        w_state_nxt = ST_DRAIN;
      end else begin
        w_state_nxt = ST_RUN;
      end
    end else begin
      case (r_state)
        ST_INIT: w_state_nxt = ST_RUN;
        ST_RUN:  w_state_nxt = ST_RUN;
        ST_DRAIN: begin
          if (w_outst_nxt == LP_ZERO) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end
        default: w_state_nxt = ST_INIT;
      endcase
    end
  end

  // Control state, pointers and PCs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_INIT;
      r_count    <= LP_ZERO;
      r_outst    <= LP_ZERO;
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_outst <= w_outst_nxt;
      if (flush) begin
        r_wr_ptr   <= {AW{1'b0}};
        r_rd_ptr   <= {AW{1'b0}};
        r_fetch_pc <= w_flush_pc;
        r_rsp_pc   <= w_flush_pc;
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + LP_FOUR;
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + LP_FOUR;
          r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
    end
  end

  // Queue storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_instr[i] <= 32'h0000_0000;
        r_q_pc[i]    <= {XLEN{1'b0}};
      end
    end else if (w_push) begin
      r_q_instr[r_wr_ptr] <= fetch_rsp_instr_fe;
      r_q_pc[r_wr_ptr]    <= r_rsp_pc;
    end
  end

  assign fetch_req_fe = w_req;
  assign fetch_pc_fe  = r_fetch_pc;
  assign valid_de0    = w_valid;
  assign instr_de0    = (r_count != LP_ZERO) ? r_q_instr[r_rd_ptr] : 32'h0000_0000;
  assign pc_de0       = (r_count != LP_ZERO) ? r_q_pc[r_rd_ptr] : {XLEN{1'b0}};
  assign empty        = (r_count == LP_ZERO) && (r_outst == LP_ZERO);

  decode_ctl_chk #(.DEPTH(DEPTH), .XLEN(XLEN), .CW(CW)) u_chk (
    .clk          (clk),
    .reset        (reset),
    .i_req        (w_req),
    .i_gnt        (fetch_gnt_fe),
    .i_flush      (flush),
    .i_fetch_pc   (r_fetch_pc),
    .i_rsp_valid  (fetch_rsp_valid_fe),
    .i_outst      (r_outst),
    .i_count      (r_count)
  );

endmodule

// Protocol checks: no orphan responses, no overfill, stable PC while a request waits.
module decode_ctl_chk #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int CW    = 3
) (
  input logic            clk,
  input logic            reset,
  input logic            i_req,
  input logic            i_gnt,
  input logic            i_flush,
  input logic [XLEN-1:0] i_fetch_pc,
  input logic            i_rsp_valid,
  input logic [CW-1:0]   i_outst,
  input logic [CW-1:0]   i_count
);

  localparam logic [CW-1:0] LP_DEPTH_C = CW'(DEPTH);

  logic            r_hold;
  logic [XLEN-1:0] r_pc;

  // Remember a pending, ungranted, unflushed request and its PC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold <= 1'b0;
      r_pc   <= {XLEN{1'b0}};
    end else begin
      r_hold <= i_req && !i_gnt && !i_flush;
      r_pc   <= i_fetch_pc;
    end
  end

  a_rsp_orphan: assert property (@(posedge clk) disable iff (!reset)
    !(i_rsp_valid && (i_outst == {CW{1'b0}})));
  a_overfill: assert property (@(posedge clk) disable iff (!reset)
    (i_count <= LP_DEPTH_C));
  a_pc_stable: assert property (@(posedge clk) disable iff (!reset)
    (!r_hold || (i_fetch_pc == r_pc)));

endmodule

// File: tb/tb_decode_ctl.sv
// Directed bench for decode_ctl: 1-cycle-latency responder, hand-computed expectations.
module tb_decode_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req_fe;
  logic [31:0] fetch_pc_fe;
  logic        fetch_gnt_fe;
  logic        fetch_rsp_valid_fe;
  logic [31:0] fetch_rsp_instr_fe;
  logic        stall_de0;
  logic        flush;
  logic [31:0] flush_pc;
  logic        valid_de0;
  logic [31:0] instr_de0;
  logic [31:0] pc_de0;
  logic        empty;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] pend[$];
  bit          rsp_en;

  always #5 clk = ~clk;

  decode_ctl #(.DEPTH(4), .XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk                (clk),
    .reset              (reset),
    .fetch_req_fe       (fetch_req_fe),
    .fetch_pc_fe        (fetch_pc_fe),
    .fetch_gnt_fe       (fetch_gnt_fe),
    .fetch_rsp_valid_fe (fetch_rsp_valid_fe),
    .fetch_rsp_instr_fe (fetch_rsp_instr_fe),
    .stall_de0          (stall_de0),
    .flush              (flush),
    .flush_pc           (flush_pc),
    .valid_de0          (valid_de0),
    .instr_de0          (instr_de0),
    .pc_de0             (pc_de0),
    .empty              (empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; record an issue at this edge and drive the next in-order response.
  task automatic cyc();
    if (fetch_req_fe && fetch_gnt_fe) pend.push_back(fetch_pc_fe);
    @(posedge clk);
    @(negedge clk);
    if (rsp_en && pend.size() > 0) begin
      fetch_rsp_valid_fe = 1'b1;
      fetch_rsp_instr_fe = 32'h0000_0033 + pend.pop_front();
    end else begin
      fetch_rsp_valid_fe = 1'b0;
      fetch_rsp_instr_fe = 32'h0000_0000;
    end
  endtask

  initial begin
    reset = 1'b0; fetch_gnt_fe = 1'b1; stall_de0 = 1'b0; flush = 1'b0;
    flush_pc = 32'h0; fetch_rsp_valid_fe = 1'b0; fetch_rsp_instr_fe = 32'h0; rsp_en = 1'b1;
    #2;
    chk("rst_req",   32'(fetch_req_fe), 32'd0);
    chk("rst_valid", 32'(valid_de0),    32'd0);
    chk("rst_instr", instr_de0,         32'h0);
    chk("rst_pc",    pc_de0,            32'h0);
    chk("rst_empty", 32'(empty),        32'd1);
    chk("rst_fpc",   fetch_pc_fe,       32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    chk("init_req", 32'(fetch_req_fe), 32'd0);

    // streaming start
    cyc();
    chk("run_req",   32'(fetch_req_fe), 32'd1);
    chk("run_fpc0",  fetch_pc_fe,       32'h0);
    chk("run_empty", 32'(empty),        32'd1);
    cyc();
    chk("fpc4",      fetch_pc_fe,       32'h4);
    chk("novalid",   32'(valid_de0),    32'd0);
    cyc();
    chk("v_first",   32'(valid_de0),    32'd1);
    chk("pc_first",  pc_de0,            32'h0);
    chk("in_first",  instr_de0,         32'h33);
    cyc();
    chk("pc_2nd",    pc_de0,            32'h4);
    chk("in_2nd",    instr_de0,         32'h37);
    cyc();
    chk("pc_3rd",    pc_de0,            32'h8);
    chk("fpc10",     fetch_pc_fe,       32'h10);

    // decode back-pressure fills all credits
    stall_de0 = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    chk("stl_req",   32'(fetch_req_fe), 32'd0);
    chk("stl_valid", 32'(valid_de0),    32'd1);
    chk("stl_head",  pc_de0,            32'h8);
    chk("stl_fpc",   fetch_pc_fe,       32'h18);
    stall_de0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rel_pc",    pc_de0,         32'hC + 32'(4 * i));
      chk("rel_valid", 32'(valid_de0), 32'd1);
    end
    chk("rel_fpc", fetch_pc_fe, 32'h28);

    // grant withheld
    fetch_gnt_fe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ng_req", 32'(fetch_req_fe), 32'd1);
      chk("ng_fpc", fetch_pc_fe,       32'h28);
    end
    fetch_gnt_fe = 1'b1;
    cyc();
    chk("g_fpc",   fetch_pc_fe,    32'h2C);
    chk("g_empty", 32'(valid_de0), 32'd0);
    cyc();
    chk("g_v",     32'(valid_de0), 32'd1);
    chk("g_pc28",  pc_de0,         32'h28);
    cyc();
    chk("g_pc2c",  pc_de0,         32'h2C);

    // flush with 2 queued, 2 in flight
    stall_de0 = 1'b1; rsp_en = 1'b0;
    cyc(); cyc();
    chk("pre_req",  32'(fetch_req_fe), 32'd0);
    chk("pre_head", pc_de0,            32'h2C);
    flush = 1'b1; flush_pc = 32'h1002;
    cyc();
    flush = 1'b0;
    chk("fl_valid", 32'(valid_de0),    32'd0);
    chk("fl_req",   32'(fetch_req_fe), 32'd0);
    chk("fl_empty", 32'(empty),        32'd0);
    chk("fl_pc",    pc_de0,            32'h0);
    rsp_en = 1'b1; stall_de0 = 1'b0;
    cyc();
    chk("dr_req1", 32'(fetch_req_fe), 32'd0);
    cyc();
    chk("dr_req2", 32'(fetch_req_fe), 32'd0);
    chk("dr_v2",   32'(valid_de0),    32'd0);
    cyc();
    chk("dr_run",  32'(fetch_req_fe), 32'd1);
    chk("dr_fpc",  fetch_pc_fe,       32'h1000);
    chk("dr_empt", 32'(empty),        32'd1);
    chk("dr_v3",   32'(valid_de0),    32'd0);
    cyc(); cyc();
    chk("nf_v",    32'(valid_de0),    32'd1);
    chk("nf_pc",   pc_de0,            32'h1000);
    chk("nf_in",   instr_de0,         32'h1033);

    // flush together with pop and response, nothing left outstanding
    flush = 1'b1; flush_pc = 32'h2000; fetch_gnt_fe = 1'b0;
    cyc();
    flush = 1'b0; fetch_gnt_fe = 1'b1;
    chk("f2_valid", 32'(valid_de0),    32'd0);
    chk("f2_req",   32'(fetch_req_fe), 32'd1);
    chk("f2_fpc",   fetch_pc_fe,       32'h2000);
    chk("f2_empty", 32'(empty),        32'd1);
    cyc();
    chk("f2_v1",    32'(valid_de0),    32'd0);
    cyc();
    chk("f2_v2",    32'(valid_de0),    32'd1);
    chk("f2_pc",    pc_de0,            32'h2000);

    // asynchronous reset mid-stream with 3 queued
    stall_de0 = 1'b1;
    cyc(); cyc();
    chk("pr_v",    32'(valid_de0),    32'd1);
    chk("pr_head", pc_de0,            32'h2000);
    chk("pr_req",  32'(fetch_req_fe), 32'd0);
    #2;
    reset = 1'b0;
    fetch_rsp_valid_fe = 1'b0; fetch_rsp_instr_fe = 32'h0;
    pend.delete();
    #1;
    chk("ar_req",   32'(fetch_req_fe), 32'd0);
    chk("ar_valid", 32'(valid_de0),    32'd0);
    chk("ar_instr", instr_de0,         32'h0);
    chk("ar_pc",    pc_de0,            32'h0);
    chk("ar_empty", 32'(empty),        32'd1);
    chk("ar_fpc",   fetch_pc_fe,       32'h0);
    @(negedge clk);
    stall_de0 = 1'b0; reset = 1'b1;
    chk("ar_init",  32'(fetch_req_fe), 32'd0);
    cyc();
    chk("ar_req1",  32'(fetch_req_fe), 32'd1);
    chk("ar_fpc1",  fetch_pc_fe,       32'h0);
    chk("ar_emp1",  32'(empty),        32'd1);
    cyc();
    chk("ar_emp2",  32'(empty),        32'd0);
    chk("ar_fpc2",  fetch_pc_fe,       32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_ctl.md
Name: decode_ctl

Overview:
Front-end sequencer feeding the decode stage. Generates sequential fetch requests, buffers in-order fetch responses in a small instruction queue, and presents one instruction per cycle to decode (valid_de0 / instr_de0 / pc_de0), honouring decode back-pressure. Handles redirect/flush by discarding queued and in-flight instructions and restarting fetch at a new PC.

Parameters:
DEPTH, 4, instruction queue entries (power of 2, >=2)
XLEN, 32, PC width
RESET_PC, 32'h0000_0000, first fetch PC after reset

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
fetch_req_fe  output  1  fetch request valid
fetch_pc_fe  output  XLEN  fetch request PC
fetch_gnt_fe  input  1  request accepted this cycle (fetch_req_fe && fetch_gnt_fe = issue)
fetch_rsp_valid_fe  input  1  response valid; responses return in issue order, latency >=1
fetch_rsp_instr_fe  input  32  raw instruction (t_rv_instr encoding)
stall_de0  input  1  decode cannot accept this cycle
flush  input  1  redirect request
flush_pc  input  XLEN  redirect target (bits [1:0] ignored, forced 0)
valid_de0  output  1  instruction presented to decode
instr_de0  output  32  queue head instruction
pc_de0  output  XLEN  queue head PC
empty  output  1  queue empty and no outstanding requests

Behaviour:
- Reset (reset==0, async): state=INIT, queue empty, outstanding=0, fetch_pc=RESET_PC, rsp_pc=RESET_PC; outputs fetch_req_fe=0, valid_de0=0, instr_de0=0, pc_de0=0, empty=1. All state updates on posedge clk otherwise.
- States: INIT -> RUN on first clock after reset release (one idle cycle, no request). RUN: normal. DRAIN: after flush while outstanding>0.
- Credits: credit = DEPTH - occupancy - outstanding. In RUN, fetch_req_fe=1 iff credit>0 (counted on registered values; a same-cycle pop does not add credit). Queue can never overflow.
- Issue: fetch_req_fe && fetch_gnt_fe -> outstanding+1, fetch_pc += 4. fetch_pc_fe holds stable while request not granted.
- Response: fetch_rsp_valid_fe in RUN -> push {instr, rsp_pc}, rsp_pc += 4, outstanding-1. Issue and response same cycle -> outstanding unchanged.
- Output: valid_de0 = (occupancy>0) && state==RUN; instr_de0/pc_de0 = head entry (0 when empty). Pop when valid_de0 && !stall_de0. Push and pop same cycle legal at any occupancy (including full, where pop frees the slot registered next cycle).
- Empty-queue response is not bypassed: earliest valid_de0 is the cycle after the response.
- Flush (highest priority, evaluated same cycle as any push/pop/issue): queue cleared, no pop counted, valid_de0=0 next cycle, fetch_pc=rsp_pc=flush_pc&~3, any issue this cycle still counts as outstanding. Next state = DRAIN if resulting outstanding>0 else RUN.
- DRAIN: fetch_req_fe=0; each response discarded (outstanding-1, no push, rsp_pc unchanged). outstanding reaches 0 -> RUN next cycle. Flush in DRAIN: reload PCs, stay in DRAIN.
- Pointers wrap modulo DEPTH; occupancy is log2(DEPTH)+1 bits.
- empty = (occupancy==0) && (outstanding==0).
- Errors (simulation assertions): response while outstanding==0; occupancy>DEPTH; fetch_pc_fe change while request pending and not granted.

Test Plan:
- Reset release, gnt tied 1, rsp returned 1 cycle after issue with instr=0x00000033+pc -> fetch_pc_fe 0x0,0x4,0x8...; valid_de0 first high 3 cycles after INIT exit, pc_de0 0x0,0x4,0x8 back-to-back one per cycle.
- stall_de0 held high 10 cycles -> exactly DEPTH(4) requests outstanding+queued, fetch_req_fe drops, head stays pc_de0=0x0; release stall -> in-order 0x0..0xC then fetch resumes at 0x10.
- gnt withheld 3 cycles -> fetch_pc_fe stable at 0x8 with fetch_req_fe=1; no pc gap after grant.
- flush with flush_pc=0x1002 while 2 requests in flight and 2 queued -> valid_de0=0 next cycle, DRAIN discards 2 responses, then first request at 0x1000 and first pc_de0=0x1000.
- flush same cycle as pop and response, outstanding=0 afterward -> direct to RUN, nothing from old stream ever appears on valid_de0.
- reset asserted mid-stream (queue 3 full) -> all outputs 0 immediately (async), after release fetch restarts at RESET_PC, empty=1 until first issue.
